adrv9001_enable_seq: RTL and testbench

ADRV9001_ENABLE_SEQ -- requirements
Module: adrv9001_enable_seq

---
 rtl/adrv9001_enable_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_adrv9001_enable_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/adrv9001_enable_seq.sv
// ADRV9001 reset and channel-enable sequencer: timed transceiver reset, then
// guarded, mutually exclusive rx/tx enables per channel. Build option: ADRV9001_IRQ_LATCH_EN.

// Per-channel enable FSM
// state    | meaning
// CH_OFF   | idle, requests evaluated
// CH_RX    | rx enable driven high
// CH_TX    | tx enable driven high
// CH_GUARD | all-off hold for GUARD_CYCLES before returning to CH_OFF
module adrv9001_enable_seq_ch #(
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic force_guard,
  input  logic rx_req,
  input  logic tx_req,
  output logic rx_en,
  output logic tx_en
);

  localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    CH_OFF,
    CH_RX,
    CH_TX,
    CH_GUARD
  } ch_state_t;

  ch_state_t   state, state_next;
  logic [15:0] cnt, cnt_next;
  logic        rx_only, tx_only;

  // Both requests together are a conflict and count as no request.
  assign rx_only = rx_req & ~tx_req;
  assign tx_only = tx_req & ~rx_req;

  always_comb begin
    state_next = state;
    cnt_next   = 16'd0;
    if (force_guard) begin
      state_next = CH_GUARD;
    end else begin
      case (state)
        CH_OFF: begin
          if (rx_only) begin
            state_next = CH_RX;
          end else if (tx_only) begin
            state_next = CH_TX;
          end
        end
        CH_RX: begin
          if (!rx_only) begin
            state_next = CH_GUARD;
          end
        end
        CH_TX: begin
          if (!tx_only) begin
            state_next = CH_GUARD;
          end
        end
        CH_GUARD: begin
          if (cnt == GUARD_LAST) begin
            state_next = CH_OFF;
          end else begin
            cnt_next = cnt + 16'd1;
          end
        end
        default: begin
          state_next = CH_GUARD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= CH_GUARD;
      cnt   <= 16'd0;
      rx_en <= 1'b0;
      tx_en <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      rx_en <= (state_next == CH_RX);
      tx_en <= (state_next == CH_TX);
    end
  end

endmodule

// Global reset sequencer
// state      | meaning
// RST_ASSERT | transceiver reset pin held low for RESET_CYCLES
// RST_WAIT   | reset released, waiting POST_RESET_CYCLES before enables
// RUN        | ready, channel FSMs free to run
module adrv9001_enable_seq #(
  parameter int unsigned RESET_CYCLES      = 1000,
  parameter int unsigned POST_RESET_CYCLES = 10000,
  parameter int unsigned GUARD_CYCLES      = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rst_req,
  input  logic       rx1_req,
  input  logic       tx1_req,
  input  logic       rx2_req,
  input  logic       tx2_req,
  input  logic       irq_in,
  input  logic       irq_clr,
  output logic       adrv9001_rstn,
  output logic       adrv9001_rx1,
  output logic       adrv9001_rx2,
  output logic       adrv9001_tx1,
  output logic       adrv9001_tx2,
  output logic       ready,
  output logic [1:0] req_err,
  output logic       irq_status
);

  localparam logic [15:0] RST_LAST  = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = 16'(POST_RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    RST_ASSERT,
    RST_WAIT,
    RUN
  } g_state_t;

  g_state_t    g_state, g_next;
  logic [15:0] g_cnt, g_cnt_next;
  logic        force_guard;

  always_comb begin
    g_next     = g_state;
    g_cnt_next = 16'd0;
    if (rst_req) begin
      g_next = RST_ASSERT;
    end else begin
      case (g_state)
        RST_ASSERT: begin
          if (g_cnt == RST_LAST) begin
            g_next = RST_WAIT;
          end else begin
            g_cnt_next = g_cnt + 16'd1;
          end
        end
        RST_WAIT: begin
          if (g_cnt == WAIT_LAST) begin
            g_next = RUN;
          end else begin
            g_cnt_next = g_cnt + 16'd1;
          end
        end
        RUN: begin
          g_next = RUN;
        end
        default: begin
          g_next = RST_ASSERT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      g_state       <= RST_ASSERT;
      g_cnt         <= 16'd0;
      adrv9001_rstn <= 1'b0;
      ready         <= 1'b0;
    end else begin
      g_state       <= g_next;
      g_cnt         <= g_cnt_next;
      adrv9001_rstn <= (g_next != RST_ASSERT);
      ready         <= (g_next == RUN);
    end
  end

  // Uses the current state so channels enter RUN with a fresh full guard;
  // rst_req is included so enables drop on the same edge rstn falls.
  assign force_guard = (g_state != RUN) | rst_req;

  adrv9001_enable_seq_ch #(
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_ch1 (
    .clk        (clk),
    .resetn     (resetn),
    .force_guard(force_guard),
    .rx_req     (rx1_req),
    .tx_req     (tx1_req),
    .rx_en      (adrv9001_rx1),
    .tx_en      (adrv9001_tx1)
  );

  adrv9001_enable_seq_ch #(
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_ch2 (
    .clk        (clk),
    .resetn     (resetn),
    .force_guard(force_guard),
    .rx_req     (rx2_req),
    .tx_req     (tx2_req),
    .rx_en      (adrv9001_rx2),
    .tx_en      (adrv9001_tx2)
  );

  assign req_err = {rx2_req & tx2_req, rx1_req & tx1_req};

  logic irq_s1, irq_s2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_s1 <= 1'b0;
      irq_s2 <= 1'b0;
    end else begin
      irq_s1 <= irq_in;
      irq_s2 <= irq_s1;
    end
  end

`ifdef ADRV9001_IRQ_LATCH_EN
  logic irq_sticky;

  // A new synchronized IRQ wins over a coincident clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_sticky <= 1'b0;
    end else if (irq_s2) begin
      irq_sticky <= 1'b1;
    end else if (irq_clr) begin
      irq_sticky <= 1'b0;
    end
  end

  assign irq_status = irq_sticky;
`else
  logic unused_irq_clr;

  assign unused_irq_clr = irq_clr;
  assign irq_status     = irq_s2;
`endif

endmodule

// File: tb/tb_adrv9001_enable_seq.sv
// Scoreboard bench for adrv9001_enable_seq: a timestamp-based reference model
// pushes expected outputs per cycle, a negedge monitor pops and compares.
module tb_adrv9001_enable_seq;

  localparam int R = 4;
  localparam int P = 6;
  localparam int G = 3;

  logic       clk;
  logic       resetn;
  logic       rst_req, rx1_req, tx1_req, rx2_req, tx2_req, irq_in, irq_clr;
  logic       adrv9001_rstn, adrv9001_rx1, adrv9001_rx2, adrv9001_tx1, adrv9001_tx2;
  logic       ready;
  logic [1:0] req_err;
  logic       irq_status;

  adrv9001_enable_seq #(
    .RESET_CYCLES     (R),
    .POST_RESET_CYCLES(P),
    .GUARD_CYCLES     (G)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .rst_req      (rst_req),
    .rx1_req      (rx1_req),
    .tx1_req      (tx1_req),
    .rx2_req      (rx2_req),
    .tx2_req      (tx2_req),
    .irq_in       (irq_in),
    .irq_clr      (irq_clr),
    .adrv9001_rstn(adrv9001_rstn),
    .adrv9001_rx1 (adrv9001_rx1),
    .adrv9001_rx2 (adrv9001_rx2),
    .adrv9001_tx1 (adrv9001_tx1),
    .adrv9001_tx2 (adrv9001_tx2),
    .ready        (ready),
    .req_err      (req_err),
    .irq_status   (irq_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         rstn, rx1, tx1, rx2, tx2, rdy, irq;
    bit [1:0]   err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: absolute cycle stamps rather than state machines.
  int cyc = 0;
  int rs_start;          // first cycle of the current rstn-low window
  int quiet_from[2];     // first all-off cycle after the last enable drop / forced stop
  int mode[2];           // 0 off, 1 rx, 2 tx
  bit in_reset = 1'b1;
  bit irq_d1, irq_d2, sticky;

  // Stimulus for the next cycle
  bit s_rst, s_rx1, s_tx1, s_rx2, s_tx2, s_irq, s_clr;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rstn",       int'(adrv9001_rstn), int'(e.rstn));
      chk("ready",      int'(ready),         int'(e.rdy));
      chk("rx1",        int'(adrv9001_rx1),  int'(e.rx1));
      chk("tx1",        int'(adrv9001_tx1),  int'(e.tx1));
      chk("rx2",        int'(adrv9001_rx2),  int'(e.rx2));
      chk("tx2",        int'(adrv9001_tx2),  int'(e.tx2));
      chk("req_err",    int'(req_err),       int'(e.err));
      chk("irq_status", int'(irq_status),    int'(e.irq));
    end
  end

  task automatic tick();
    int  c;
    bit  run_c;
    bit  rq[2];
    bit  tq[2];
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    c = cyc - 1;
    rq[0] = rx1_req; tq[0] = tx1_req;
    rq[1] = rx2_req; tq[1] = tx2_req;
    if (in_reset) begin
      mode[0] = 0; mode[1] = 0;
      irq_d1 = 1'b0; irq_d2 = 1'b0; sticky = 1'b0;
    end else begin
      run_c = (c >= rs_start + R + P);
      for (int ch = 0; ch < 2; ch++) begin
        bit ex_rx, ex_tx;
        ex_rx = rq[ch] & ~tq[ch];
        ex_tx = tq[ch] & ~rq[ch];
        if (!run_c || rst_req) begin
          mode[ch] = 0;
          quiet_from[ch] = c + 1;
        end else if ((mode[ch] == 1 && !ex_rx) || (mode[ch] == 2 && !ex_tx)) begin
          mode[ch] = 0;
          quiet_from[ch] = c + 1;
        end else if (mode[ch] == 0 && c >= quiet_from[ch] + G) begin
          if (ex_rx) mode[ch] = 1;
          else if (ex_tx) mode[ch] = 2;
        end
      end
      if (rst_req) rs_start = c + 1;
      sticky = irq_d2 | (sticky & ~irq_clr);
      irq_d2 = irq_d1;
      irq_d1 = irq_in;
    end
    rst_req = s_rst; rx1_req = s_rx1; tx1_req = s_tx1;
    rx2_req = s_rx2; tx2_req = s_tx2; irq_in = s_irq; irq_clr = s_clr;
    e.cyc = cyc;
    e.err = {s_rx2 & s_tx2, s_rx1 & s_tx1};
    if (in_reset) begin
      e.rstn = 0; e.rdy = 0; e.rx1 = 0; e.tx1 = 0; e.rx2 = 0; e.tx2 = 0; e.irq = 0;
    end else begin
      e.rstn = (cyc >= rs_start + R);
      e.rdy  = (cyc >= rs_start + R + P);
      e.rx1  = (mode[0] == 1);
      e.tx1  = (mode[0] == 2);
      e.rx2  = (mode[1] == 1);
      e.tx2  = (mode[1] == 2);
`ifdef ADRV9001_IRQ_LATCH_EN
      e.irq  = sticky;
`else
      e.irq  = irq_d2;
`endif
    end
    exp_q.push_back(e);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic release_reset();
    resetn = 1'b1;
    in_reset = 1'b0;
    rs_start = cyc;
    quiet_from[0] = cyc;
    quiet_from[1] = cyc;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(9) == 0) s_rx1 = ~s_rx1;
      if ($urandom_range(9) == 0) s_tx1 = ~s_tx1;
      if ($urandom_range(9) == 0) s_rx2 = ~s_rx2;
      if ($urandom_range(9) == 0) s_tx2 = ~s_tx2;
      s_rst = ($urandom_range(149) == 0);
      s_irq = ($urandom_range(7) == 0);
      s_clr = ($urandom_range(5) == 0);
      tick();
    end
    s_rst = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    rst_req = 0; rx1_req = 0; tx1_req = 0; rx2_req = 0; tx2_req = 0;
    irq_in = 0; irq_clr = 0;
    s_rst = 0; s_rx1 = 0; s_tx1 = 0; s_rx2 = 0; s_tx2 = 0; s_irq = 0; s_clr = 0;
    irq_d1 = 0; irq_d2 = 0; sticky = 0;
    mode[0] = 0; mode[1] = 0;
    rs_start = 0; quiet_from[0] = 0; quiet_from[1] = 0;

    ticks(3);
    release_reset();

    // Power-up sequence, then rx1, then a switch to tx1 through the guard
    s_rx1 = 1; ticks(25);
    s_rx1 = 0; s_tx1 = 1; ticks(12);
    // Channel 2 conflict while channel 1 transmits
    s_rx2 = 1; s_tx2 = 1; ticks(5);
    s_rx2 = 0; s_tx2 = 0;
    // Reset request during tx, re-requested two cycles later
    s_rst = 1; tick();
    s_rst = 0; tick();
    s_rst = 1; tick();
    s_rst = 0; ticks(25);
    // IRQ pulse, then a clear coinciding with a new synchronized IRQ
    s_irq = 1; tick();
    s_irq = 0; ticks(6);
    s_irq = 1; tick();
    s_irq = 0; ticks(1);
    s_clr = 1; tick();
    s_clr = 0; ticks(4);
    s_clr = 1; tick();
    s_clr = 0; ticks(4);

    random_phase(3000);

    // Asynchronous reset in the middle of a tx burst
    s_rx1 = 0; s_tx1 = 1; s_rx2 = 0; s_tx2 = 0; s_irq = 1; s_clr = 0;
    ticks(25);
    s_irq = 0;
    #5;
    resetn = 1'b0;
    in_reset = 1'b1;
    #1;
    chk("async_rstn",  int'(adrv9001_rstn), 0);
    chk("async_ready", int'(ready), 0);
    chk("async_en",    int'({adrv9001_rx1, adrv9001_tx1, adrv9001_rx2, adrv9001_tx2}), 0);
    chk("async_irq",   int'(irq_status), 0);
    ticks(3);
    release_reset();

    random_phase(1500);
    s_rx1 = 0; s_tx1 = 0; s_rx2 = 0; s_tx2 = 0; s_irq = 0; s_clr = 0;
    ticks(3);

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
